// File: rtl/bcd_counter_8421.sv
// ---------------------------------------------------------------------------
// bcd_counter_8421
// Single-decade 8421 BCD up/down counter with a built-in clock prescaler.
// One count step is taken every DIV enabled clocks; a one-cycle carry pulse
// marks the 9->0 (up) or 0->9 (down) wrap so decades can be cascaded.
// The digit output is always a legal BCD code 0-9.
//
// Parameters:
//   DIV      prescaler division ratio, 1 .. 2^32-1
//   PW       prescaler width, derived from DIV (minimum 1)
//
// Ports:
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   en       count enable; gates the prescaler
//   up       direction: 1 = up, 0 = down (sampled only on a step)
//   load     synchronous load strobe; priority over stepping
//   load_val BCD value to load (values above 9 load 0)
//   bcd      current digit, registered
//   carry    one-cycle wrap pulse, registered
//
// Optional build macro:
//   BCD_COUNTER_SATURATE_EN  saturate at 9/0 instead of wrapping; carry then
//                            flags each blocked step (overflow/underflow).
// ---------------------------------------------------------------------------
module bcd_counter_8421 #(
  parameter int unsigned DIV = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] bcd,
  output logic       carry
);

  localparam int unsigned     PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic          step;
  logic [3:0]    bcd_next;
  logic          carry_next;

  // A step is taken on the last prescaler count of an enabled, non-load clock.
  always_comb begin
    step = en & ~load & (presc == PRESC_LAST);
  end

  // Digit value and carry to commit if a step is taken this clock.
  always_comb begin
    bcd_next   = bcd;
    carry_next = 1'b0;
    if (bcd > 4'd9) begin
      // Illegal code (e.g. upset): recover to 0 without a carry.
      bcd_next = '0;
    end else if (up) begin
      if (bcd == 4'd9) begin
`ifdef BCD_COUNTER_SATURATE_EN
        bcd_next = 4'd9;
`else
        bcd_next = '0;
`endif
        carry_next = 1'b1;
      end else begin
        bcd_next = bcd + 4'd1;
      end
    end else begin
      if (bcd == 4'd0) begin
`ifdef BCD_COUNTER_SATURATE_EN
        bcd_next = '0;
`else
        bcd_next = 4'd9;
`endif
        carry_next = 1'b1;
      end else begin
        bcd_next = bcd - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      bcd   <= '0;
      carry <= 1'b0;
    end else if (load) begin
      presc <= '0;
      bcd   <= (load_val > 4'd9) ? 4'd0 : load_val;
      carry <= 1'b0;
    end else begin
      carry <= 1'b0;
      if (en) begin
        if (step) begin
          presc <= '0;
          bcd   <= bcd_next;
          carry <= carry_next;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_counter_8421.sv
// ---------------------------------------------------------------------------
// tb_bcd_counter_8421
// Self-checking bench for bcd_counter_8421 with DIV=4. A behavioural model
// (enabled-clock counting modulo DIV, digit arithmetic modulo 10) predicts
// bcd/carry; one process compares DUT against the model on every falling
// edge. Directed sequences add literal expectations that pin the model,
// followed by randomized en/up/load/reset stimulus.
// ---------------------------------------------------------------------------
module tb_bcd_counter_8421;

  localparam int unsigned DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] bcd;
  logic       carry;

  int vectors;
  int miscompares;

  // Behavioural reference state
  int m_cnt;
  int m_bcd;
  bit m_carry;

  bcd_counter_8421 #(.DIV(DIV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .carry    (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: counts enabled clocks modulo DIV, digit modulo 10.
  always @(posedge clk or negedge rst_n) begin
    int nb;
    bit nc;
    if (!rst_n) begin
      m_cnt   <= 0;
      m_bcd   <= 0;
      m_carry <= 1'b0;
    end else if (load) begin
      m_cnt   <= 0;
      m_bcd   <= (int'(load_val) <= 9) ? int'(load_val) : 0;
      m_carry <= 1'b0;
    end else if (en && (m_cnt + 1 == DIV)) begin
      nc = 1'b0;
      if (m_bcd > 9) nb = 0;
      else if (up) begin
        nb = (m_bcd + 1) % 10;
        nc = (m_bcd == 9);
`ifdef BCD_COUNTER_SATURATE_EN
        if (nc) nb = 9;
`endif
      end else begin
        nb = (m_bcd + 9) % 10;
        nc = (m_bcd == 0);
`ifdef BCD_COUNTER_SATURATE_EN
        if (nc) nb = 0;
`endif
      end
      m_cnt   <= 0;
      m_bcd   <= nb;
      m_carry <= nc;
    end else begin
      if (en) m_cnt <= m_cnt + 1;
      m_carry <= 1'b0;
    end
  end

  // Compare process: outputs are meaningful on every cycle.
  always @(negedge clk) begin
    check("bcd_vs_model", int'(bcd), m_bcd);
    check("carry_vs_model", int'(carry), int'(m_carry));
  end

  // Wait n rising edges, then move 2 time units past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    #13;
    check("reset_bcd", int'(bcd), 0);
    check("reset_carry", int'(carry), 0);
    rst_n = 1'b1;
    tick(1);

    // Count up 44 clocks: wrap with carry exactly at clock 40
    en = 1'b1; up = 1'b1;
    tick(3);
    check("up_no_step_yet", int'(bcd), 0);
    tick(1);
    check("up_first_step", int'(bcd), 1);
    tick(32);
    check("up_at_9", int'(bcd), 9);
    check("up_carry_low_at_9", int'(carry), 0);
    tick(4);
    check("up_wrap_bcd", int'(bcd), 0);
    check("up_wrap_carry", int'(carry), 1);
    tick(1);
    check("up_carry_one_cycle", int'(carry), 0);
    tick(3);
    check("up_after_wrap", int'(bcd), 1);

    // Load 3, count down through 0 -> 9
    en = 1'b0;
    do_load(4'd3);
    check("load3", int'(bcd), 3);
    en = 1'b1; up = 1'b0;
    tick(4);
    check("down_2", int'(bcd), 2);
    tick(8);
    check("down_0", int'(bcd), 0);
    tick(4);
    check("down_wrap_bcd", int'(bcd), 9);
    check("down_wrap_carry", int'(carry), 1);

    // Illegal load value loads 0 and clears the prescaler
    tick(2);
    do_load(4'd12);
    check("load12_bcd", int'(bcd), 0);
    check("load12_carry", int'(carry), 0);
    up = 1'b1;
    tick(3);
    check("load12_presc_cleared", int'(bcd), 0);
    tick(1);
    check("load12_next_step", int'(bcd), 1);

    // Enable gating from 5: 1,1,0,0,0,1,1
    en = 1'b0;
    do_load(4'd5);
    en = 1'b1; tick(2);
    en = 1'b0; tick(3);
    en = 1'b1; tick(1);
    check("gated_hold", int'(bcd), 5);
    tick(1);
    check("gated_step", int'(bcd), 6);

    // Load collides with a due step at 9: load wins, no carry
    en = 1'b0;
    do_load(4'd9);
    en = 1'b1; up = 1'b1;
    tick(3);
    load = 1'b1; load_val = 4'd7;
    tick(1);
    load = 1'b0;
    check("collide_bcd", int'(bcd), 7);
    check("collide_carry", int'(carry), 0);

    // Asynchronous reset between edges right after a carry pulse
    do_load(4'd9);
    tick(4);
    check("pre_reset_carry", int'(carry), 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_bcd", int'(bcd), 0);
    check("async_reset_carry", int'(carry), 0);
    tick(1);
    #1 rst_n = 1'b1;
    tick(1);

`ifdef BCD_COUNTER_SATURATE_EN
    en = 1'b0;
    do_load(4'd9);
    en = 1'b1; up = 1'b1;
    tick(4);
    check("sat_hold_9", int'(bcd), 9);
    check("sat_carry", int'(carry), 1);
    tick(1);
    check("sat_carry_one_cycle", int'(carry), 0);
`endif

    // Randomized stimulus against the model
    for (int i = 0; i < 3000; i++) begin
      en       = ($urandom_range(0, 9) < 7);
      up       = $urandom_range(0, 1) == 1;
      load     = ($urandom_range(0, 39) == 0);
      load_val = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 499) == 0) begin
        #1 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      tick(1);
    end
    load = 1'b0; en = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
